// File: rtl/seg7_to_binary.sv
// seg7_to_binary: recovers the binary value shown on DIGITS raw 7-segment
// patterns. Each pattern is decoded to a BCD digit and illegal patterns are
// flagged. The BCD is then converted to binary by an iterative reverse
// double-dabble that performs one shift/adjust step per clock.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; seg_in digit k at [7k+6:7k] (abcdefg)
//   out_valid / out_ready output handshake
//   binary_out            converted value (BIN_W bits)
//   bcd_out               decoded BCD, digit k at [4k+3:4k]
//   err                   at least one digit held an illegal pattern
//
// Optional feature macro: SEG7_BLANK_LEADING_EN
//   When defined, a blank (0000000) digit other than digit 0 decodes as 0
//   provided every more-significant digit is also blank.
module seg7_to_binary #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7*DIGITS-1:0]   seg_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      binary_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BIN_W-1:0]    binary_q, binary_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                err_q, err_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [BCD_W-1:0]    dec_bcd;
    logic                dec_err;
    logic [WORK_W-1:0]   work_step;

    // Strict segment decode: returns {illegal, digit}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b0, 4'd0};
            7'b0110000: r = {1'b0, 4'd1};
            7'b1101101: r = {1'b0, 4'd2};
            7'b1111001: r = {1'b0, 4'd3};
            7'b0110011: r = {1'b0, 4'd4};
            7'b1011011: r = {1'b0, 4'd5};
            7'b1011111: r = {1'b0, 4'd6};
            7'b1110000: r = {1'b0, 4'd7};
            7'b1111111: r = {1'b0, 4'd8};
            7'b1111011: r = {1'b0, 4'd9};
            default:    r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    // One reverse double-dabble step: shift right, then pull any BCD digit >= 8 down by 3.
    function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        logic [3:0]        dg;
        s = w >> 1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dg = s[BIN_W + 4*k +: 4];
            if (dg >= 4'd8) begin
                s[BIN_W + 4*k +: 4] = dg - 4'd3;
            end
        end
        return s;
    endfunction

`ifdef SEG7_BLANK_LEADING_EN
    logic blank_above;
`endif

    // Decode every digit of the presented frame, most significant first.
    always_comb begin
        logic [4:0] r;
        logic [6:0] seg;
        dec_bcd = '0;
        dec_err = 1'b0;
`ifdef SEG7_BLANK_LEADING_EN
        blank_above = 1'b1;
`endif
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            seg = seg_in[7*k +: 7];
            r   = decode_seg(seg);
`ifdef SEG7_BLANK_LEADING_EN
            // Leading blanks stand for suppressed zeros; the ones digit must still show.
            if ((seg == 7'b0000000) && (k != 0) && blank_above) begin
                r = 5'b0;
            end
            blank_above = blank_above & (seg == 7'b0000000);
`endif
            dec_bcd[4*k +: 4] = r[3:0];
            dec_err           = dec_err | r[4];
        end
    end

    assign work_step = dd_step(work_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        binary_d  = binary_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (dec_err) begin
                        err_d    = 1'b1;
                        bcd_d    = '0;
                        binary_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        bcd_d   = dec_bcd;
                        work_d  = {dec_bcd, BIN_W'(0)};
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    binary_d = work_step[BIN_W-1:0];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            binary_q    <= '0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            binary_q    <= binary_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign binary_out = binary_q;
    assign bcd_out    = bcd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_to_binary.sv
// Testbench for seg7_to_binary: directed cases plus randomized frames checked
// against a digit-lookup / decimal-arithmetic reference model.
module tb_seg7_to_binary;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned BIN_W  = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [7*DIGITS-1:0]  seg_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     binary_out;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 err;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [10];

    seg7_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .seg_in     (seg_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .bcd_out    (bcd_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: look each pattern up in the digit table, then form the value in decimal.
    task automatic ref_model(input logic [13:0] seg, output int val,
                             output logic [7:0] bcd, output logic e);
        logic [6:0] p;
        int d;
`ifdef SEG7_BLANK_LEADING_EN
        logic blank_above;
        blank_above = 1'b1;
`endif
        e = 1'b0; val = 0; bcd = 8'h00;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            p = seg[7*k +: 7];
            d = -1;
            for (int i = 0; i < 10; i++) if (seg_tab[i] == p) d = i;
`ifdef SEG7_BLANK_LEADING_EN
            if (p == 7'd0 && k != 0 && blank_above) d = 0;
            blank_above = blank_above & (p == 7'd0);
`endif
            if (d < 0) e = 1'b1;
            else begin
                val = val * 10 + d;
                bcd[4*k +: 4] = 4'(d);
            end
        end
        if (e) begin val = 0; bcd = 8'h00; end
    endtask

    // Offer one frame, hold the result for bp cycles of backpressure, then retire it.
    task automatic run_frame(input string tag, input logic [13:0] seg, input int bp);
        int exp_val, n;
        logic [7:0] exp_bcd;
        logic exp_err;
        ref_model(seg, exp_val, exp_bcd, exp_err);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        seg_in    = seg;
        out_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seg_in   = $urandom();
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check({tag, ".latency"}, 32'(n), exp_err ? 32'd0 : 32'(BIN_W));
        check({tag, ".binary"}, 32'(binary_out), 32'(exp_val));
        check({tag, ".bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        // A competing frame offered under backpressure must be ignored.
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            seg_in   = {seg_tab[1], seg_tab[1]};
            @(posedge clk); @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_binary"}, 32'(binary_out), 32'(exp_val));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, ".retire_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".retire_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [13:0] seg;
        int bp, seen;
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; seg_in = '0;
        #23;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.binary", 32'(binary_out), 32'd0);
        check("reset.bcd", 32'(bcd_out), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_frame("d24", {seg_tab[2], seg_tab[4]}, 0);
        check("d24.value", 32'(binary_out), 32'h18);
        run_frame("d99", {seg_tab[9], seg_tab[9]}, 0);
        check("d99.value", 32'(binary_out), 32'h63);
        run_frame("d00", {seg_tab[0], seg_tab[0]}, 0);
        run_frame("bad_tens", {7'b0000001, seg_tab[4]}, 0);
        check("bad_tens.err_held", 32'(err), 32'd1);
        run_frame("bp57", {seg_tab[5], seg_tab[7]}, 5);
        check("bp57.value", 32'(binary_out), 32'h39);
        run_frame("blank_tens", {7'b0000000, seg_tab[7]}, 0);
`ifdef SEG7_BLANK_LEADING_EN
        check("blank_tens.value", 32'(binary_out), 32'd7);
`else
        check("blank_tens.err_flag", 32'(err), 32'd1);
`endif
        run_frame("blank_ones", {seg_tab[7], 7'b0000000}, 0);
        check("blank_ones.err_flag", 32'(err), 32'd1);
        run_frame("blank_both", 14'd0, 0);

        // Asynchronous reset during the third conversion step.
        in_valid = 1'b1; seg_in = {seg_tab[2], seg_tab[4]};
        @(posedge clk); @(negedge clk); in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.binary", 32'(binary_out), 32'd0);
        check("mid_rst.bcd", 32'(bcd_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst.no_output", 32'(seen), 32'd0);

        // Randomized frames: mostly legal values, some arbitrary patterns.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) seg = 14'($urandom());
            else seg = {seg_tab[$urandom_range(0, 9)], seg_tab[$urandom_range(0, 9)]};
            bp = $urandom_range(0, 3);
            run_frame("rand", seg, bp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
